vga_sync_receiver: RTL and testbench

Sink-side companion to the VGA output path. Samples `hsync`, `vsync`, `blank_n` and the 8-bit colour buses on `clk`, and locks onto 640x480@60 timing. It rebuilds pixel coordinates and flags timing faults. It also reports per-frame counts of red, green and blue pixels. It sits on the board loopback or the test harness, so displayed frames (border, player, blocks, win and game-over screens) can be checked in hardware without a monitor.

---
 rtl/vga_sync_receiver.sv | 202 ++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing receiver: recovers pixel coordinates, locks onto the sync timing and flags faults.
// Build with VGA_RX_COLOR_COUNT_EN defined to add per-frame red/green/blue pixel counters.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_valid,
  output logic        locked,
  output logic        frame_done,
  output logic [18:0] red_count,
  output logic [18:0] green_count,
  output logic [18:0] blue_count,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err
);

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  logic       hs_q, vs_q, bn_q, hs_prev_q, vs_prev_q;
  logic [2:0] col_q;
  logic       hs_fall, vs_fall, line_bad, frame_bad;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic       rx_valid_q, rx_valid_d;
  state_t     state_q, state_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic       locked_q, locked_d, frame_done_q, frame_done_d;
  logic       h_err_q, h_err_d, v_err_q, v_err_d, blank_err_q, blank_err_d;

  assign hs_fall   = hs_prev_q & ~hs_q;
  assign vs_fall   = vs_prev_q & ~vs_q;
  assign line_bad  = hs_fall && (hcnt_q != H_LAST);
  assign frame_bad = vs_fall && (vcnt_q != V_LAST);

  // Coordinates are computed from the next counter values so the outputs
  // land two cycles after the pins, aligned with the registered blank_n/colour.
  always_comb begin
    hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
    if (hs_fall) hcnt_d = '0;
    vcnt_d = vcnt_q;
    if (hs_fall && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
    if (vs_fall) vcnt_d = '0;
    rx_valid_d = (hcnt_d >= H_START) && (hcnt_d <= H_END) &&
                 (vcnt_d >= V_START) && (vcnt_d <= V_END);
    rx_x_d = rx_valid_d ? hcnt_d - H_START : '0;
    rx_y_d = rx_valid_d ? vcnt_d - V_START : '0;
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    h_err_d     = h_err_q;
    v_err_d     = v_err_q;
    blank_err_d = blank_err_q;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d    = TRACK;
          good_cnt_d = '0;
        end
      end
      TRACK: begin
        if (line_bad || frame_bad) begin
          good_cnt_d = '0;
        end else if (vs_fall) begin
          if (good_cnt_q + 8'd1 == LOCK_N) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (line_bad) h_err_d = 1'b1;
        if (frame_bad) v_err_d = 1'b1;
        if (line_bad || frame_bad) state_d = TRACK;
        if (bn_q != rx_valid_d) blank_err_d = 1'b1;
      end
      default: state_d = SEARCH;
    endcase
    locked_d     = (state_d == LOCKED);
    frame_done_d = vs_fall && (state_q != SEARCH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      bn_q         <= 1'b0;
      col_q        <= '0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      hcnt_q       <= CNT_MAX;
      vcnt_q       <= CNT_MAX;
      rx_x_q       <= '0;
      rx_y_q       <= '0;
      rx_valid_q   <= 1'b0;
      state_q      <= SEARCH;
      good_cnt_q   <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
      blank_err_q  <= 1'b0;
    end else begin
      hs_q         <= hsync;
      vs_q         <= vsync;
      bn_q         <= blank_n;
      col_q        <= {VGA_B[7], VGA_G[7], VGA_R[7]};
      hs_prev_q    <= hs_q;
      vs_prev_q    <= vs_q;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      rx_x_q       <= rx_x_d;
      rx_y_q       <= rx_y_d;
      rx_valid_q   <= rx_valid_d;
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      h_err_q      <= h_err_d;
      v_err_q      <= v_err_d;
      blank_err_q  <= blank_err_d;
    end
  end

  assign rx_x       = rx_x_q;
  assign rx_y       = rx_y_q;
  assign rx_valid   = rx_valid_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign h_err      = h_err_q;
  assign v_err      = v_err_q;
  assign blank_err  = blank_err_q;

  logic unused_colour_lsbs;
  assign unused_colour_lsbs = &{1'b0, VGA_R[6:0], VGA_G[6:0], VGA_B[6:0]};

`ifdef VGA_RX_COLOR_COUNT_EN
  // Index 0 = red, 1 = green, 2 = blue; the pixel on the vsync-fall cycle is dropped.
  for (genvar gi = 0; gi < 3; gi++) begin : g_color
    logic [18:0] acc_q, acc_d, cnt_q, cnt_d;
    always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (vs_fall) begin
        cnt_d = acc_q;
        acc_d = '0;
      end else if (rx_valid_d && col_q[gi]) begin
        acc_d = acc_q + 19'd1;
      end
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
    end
  end
  assign red_count   = g_color[0].cnt_q;
  assign green_count = g_color[1].cnt_q;
  assign blue_count  = g_color[2].cnt_q;
`else
  logic unused_colour_bits;
  assign unused_colour_bits = &{1'b0, col_q};
  assign red_count   = '0;
  assign green_count = '0;
  assign blue_count  = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a shrunken raster (40x20 clocks, 24x12 visible) to keep runs short.
module tb_vga_sync_receiver;
  localparam int HT = 40, HS = 4, HBP = 4, HA = 24;
  localparam int VT = 20, VS = 2, VBP = 3, VA = 12;
  localparam int LOCKN = 2;
  localparam int X0 = HS + HBP, Y0 = VS + VBP;
  localparam int FULL = HA * VA;
`ifdef VGA_RX_COLOR_COUNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hsync = 1'b1, vsync = 1'b1, blank_n = 1'b0;
  logic [7:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic [9:0] rx_x, rx_y;
  logic rx_valid, locked, frame_done, h_err, v_err, blank_err;
  logic [18:0] red_count, green_count, blue_count;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
    .LOCK_FRAMES(LOCKN)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .rx_x(rx_x), .rx_y(rx_y), .rx_valid(rx_valid), .locked(locked),
    .frame_done(frame_done), .red_count(red_count), .green_count(green_count),
    .blue_count(blue_count), .h_err(h_err), .v_err(v_err), .blank_err(blank_err)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Called at each negedge before driving pin cycle (l,c); registered outputs reflect pin cycle c-2.
  task automatic observe(input int f, input int l, input int c);
    if (l == 0 && c == 1 && (f == 2 || f == 11)) check_eq("locked_pre", int'(locked), 0);
    if (l == 0 && c == 2) begin
      case (f)
        0: check_eq("frame_done_search", int'(frame_done), 0);
        1: begin
          check_eq("frame_done_track", int'(frame_done), 1);
          check_eq("locked_f1", int'(locked), 0);
        end
        2: begin
          check_eq("locked_rise", int'(locked), 1);
          check_eq("red_single", int'(red_count), CE * 1);
          check_eq("green_single", int'(green_count), 0);
        end
        3: begin
          check_eq("red_full", int'(red_count), CE * FULL);
          check_eq("blue_full", int'(blue_count), 0);
          check_eq("frame_done_pulse", int'(frame_done), 1);
          check_eq("h_err_clean", int'(h_err), 0);
          check_eq("v_err_clean", int'(v_err), 0);
          check_eq("blank_err_clean", int'(blank_err), 0);
        end
        4: check_eq("locked_f4", int'(locked), 1);
        7: begin
          check_eq("relocked", int'(locked), 1);
          check_eq("h_err_sticky", int'(h_err), 1);
          check_eq("red_f6", int'(red_count), CE * FULL);
          check_eq("blank_err_pre", int'(blank_err), 0);
        end
        8: begin
          check_eq("blank_err_set", int'(blank_err), 1);
          check_eq("red_blank_frame", int'(red_count), CE * FULL);
          check_eq("locked_blank", int'(locked), 1);
        end
        10: check_eq("locked_after_1good", int'(locked), 0);
        11: check_eq("locked_after_rst", int'(locked), 1);
        12: begin
          check_eq("v_err_set", int'(v_err), 1);
          check_eq("locked_v_err", int'(locked), 0);
          check_eq("h_err_after_rst", int'(h_err), 0);
        end
        default: ;
      endcase
    end
    if (f == 3 && l == 0 && c == 3) check_eq("frame_done_1cyc", int'(frame_done), 0);
    if (f == 1 && l == Y0 && c == X0 + 1) check_eq("rx_valid_pre", int'(rx_valid), 0);
    if (f == 1 && l == Y0 && c == X0 + 2) begin
      check_eq("rx_x_first", int'(rx_x), 0);
      check_eq("rx_y_first", int'(rx_y), 0);
      check_eq("rx_valid_first", int'(rx_valid), 1);
    end
    if (f == 1 && l == Y0 + VA - 1 && c == X0 + HA + 1) begin
      check_eq("rx_x_last", int'(rx_x), HA - 1);
      check_eq("rx_y_last", int'(rx_y), VA - 1);
      check_eq("rx_valid_last", int'(rx_valid), 1);
    end
    if (f == 1 && l == Y0 + VA - 1 && c == X0 + HA + 2) check_eq("rx_valid_post", int'(rx_valid), 0);
    if (f == 4 && l == 9 && c == 3) begin
      check_eq("h_err_short", int'(h_err), 1);
      check_eq("locked_short", int'(locked), 0);
      check_eq("v_err_short", int'(v_err), 0);
    end
    if (f == 8 && l == 10 && c == 20) rst = 1'b0;
    if (f == 8 && l == 10 && c == 21) begin
      check_eq("rst_locked", int'(locked), 0);
      check_eq("rst_h_err", int'(h_err), 0);
      check_eq("rst_blank_err", int'(blank_err), 0);
      check_eq("rst_red", int'(red_count), 0);
      check_eq("rst_rx_valid", int'(rx_valid), 0);
      rst = 1'b1;
    end
  endtask

  // mode: 0 no colour, 1 single red pixel at (0,0), 2 full red screen
  task automatic run_frame(input int f, input int lines, input int short_line,
                           input int mode, input bit blank_low);
    bit act;
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < ((l == short_line) ? HT - 1 : HT); c++) begin
        @(negedge clk);
        observe(f, l, c);
        act = (l >= Y0) && (l < Y0 + VA) && (c >= X0) && (c < X0 + HA);
        hsync   = (c >= HS);
        vsync   = (l >= VS);
        blank_n = act && !blank_low;
        vga_r   = ((mode == 2 && act) || (mode == 1 && l == Y0 && c == X0)) ? 8'hFF : 8'h00;
        vga_g   = '0;
        vga_b   = '0;
      end
    end
    $display("frame %0d: locked=%0d h_err=%0d v_err=%0d blank_err=%0d red=%0d",
             f, locked, h_err, v_err, blank_err, red_count);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_locked", int'(locked), 0);
    check_eq("reset_rx_valid", int'(rx_valid), 0);
    check_eq("reset_frame_done", int'(frame_done), 0);
    check_eq("reset_h_err", int'(h_err), 0);
    check_eq("reset_red", int'(red_count), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(0,  VT,     -1, 0, 1'b0);
    run_frame(1,  VT,     -1, 1, 1'b0);
    run_frame(2,  VT,     -1, 2, 1'b0);
    run_frame(3,  VT,     -1, 0, 1'b0);
    run_frame(4,  VT,      8, 0, 1'b0);
    run_frame(5,  VT,     -1, 2, 1'b0);
    run_frame(6,  VT,     -1, 2, 1'b0);
    run_frame(7,  VT,     -1, 2, 1'b1);
    run_frame(8,  VT,     -1, 0, 1'b0);
    run_frame(9,  VT,     -1, 0, 1'b0);
    run_frame(10, VT,     -1, 0, 1'b0);
    run_frame(11, VT - 1, -1, 0, 1'b0);
    run_frame(12, VT,     -1, 0, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
